axi_dma_ch_sched: RTL and testbench

//  Multi-channel descriptor scheduler for the next-generation DMA. Holds NUM_CH channels of NUM_DESC

---
 rtl/axi_dma_ch_sched_if.sv | 23 ++
 rtl/axi_dma_ch_sched.sv | 129 ++++++++++++
 tb/tb_axi_dma_ch_sched.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_ch_sched_if.sv
// axi_dma_ch_sched_if: descriptor request and completion link between scheduler and engine
interface axi_dma_ch_sched_if #(
  parameter int ADDR_W  = 32,
  parameter int BYTES_W = 32,
  parameter int CH_W    = 2
);
  logic               eng_req_valid_o;
  logic               eng_req_ready_i;
  logic [ADDR_W-1:0]  eng_src_o;
  logic [ADDR_W-1:0]  eng_dst_o;
  logic [BYTES_W-1:0] eng_byt_o;
  logic [CH_W-1:0]    eng_ch_o;
  logic               eng_done_i;
  logic               eng_err_i;
  modport master (
    output eng_req_valid_o, eng_src_o, eng_dst_o, eng_byt_o, eng_ch_o,
    input  eng_req_ready_i, eng_done_i, eng_err_i
  );
  modport slave (
    input  eng_req_valid_o, eng_src_o, eng_dst_o, eng_byt_o, eng_ch_o,
    output eng_req_ready_i, eng_done_i, eng_err_i
  );
endinterface

// File: rtl/axi_dma_ch_sched.sv
// axi_dma_ch_sched: round-robin multi-channel descriptor scheduler feeding one DMA engine
module axi_dma_ch_sched #(
  parameter int NUM_CH   = 4,
  parameter int NUM_DESC = 2,
  parameter int ADDR_W   = 32,
  parameter int BYTES_W  = 32,
  localparam int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CH-1:0]                   ch_go_i,
  input  logic [NUM_CH-1:0]                   ch_abort_i,
  input  logic [NUM_CH*NUM_DESC*ADDR_W-1:0]   ch_desc_src_i,
  input  logic [NUM_CH*NUM_DESC*ADDR_W-1:0]   ch_desc_dst_i,
  input  logic [NUM_CH*NUM_DESC*BYTES_W-1:0]  ch_desc_byt_i,
  input  logic [NUM_CH*NUM_DESC-1:0]          ch_desc_en_i,
  input  logic [NUM_CH-1:0]                   irq_mask_i,
  input  logic [NUM_CH-1:0]                   irq_clr_i,
  axi_dma_ch_sched_if.master                  eng,
  output logic [NUM_CH-1:0]                   ch_busy_o,
  output logic [NUM_CH-1:0]                   ch_done_o,
  output logic [NUM_CH-1:0]                   ch_err_o,
  output logic                                irq_done_o,
  output logic                                irq_error_o
);
  localparam int DI_W = $clog2(NUM_DESC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [NUM_CH-1:0] pend_q, done_q, err_q, avail, ch_oh, act_oh, clr_mask;
  logic [2*NUM_CH-1:0] avail2;
  logic abort_q, vld_q, valid, gnt_ok, sel_ok, fin_done, fin_end;
  logic [CH_W-1:0] ch_q, rr_q, gnt_ch;
  logic [DI_W-1:0] idx_q, sel_d;
  logic [ADDR_W-1:0] src_d, dst_d;
  logic [BYTES_W-1:0] byt_d;
  assign avail    = pend_q & ~ch_abort_i;
  assign avail2   = {avail, avail};
  assign ch_oh    = NUM_CH'(1) << ch_q;
  assign act_oh   = state_q != IDLE ? ch_oh : '0;
  // Pick the first grantable channel at or after the round-robin pointer
  always_comb begin
    gnt_ok = 1'b0;
    gnt_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (avail2[int'(rr_q) + i]) begin
        gnt_ok = 1'b1;
        gnt_ch = CH_W'((int'(rr_q) + i) % NUM_CH);
      end
    end
  end
  // Find the lowest usable descriptor at or after the current index of the active channel
  always_comb begin
    sel_ok = 1'b0;
    sel_d  = '0;
    src_d  = '0;
    dst_d  = '0;
    byt_d  = '0;
    for (int d = NUM_DESC - 1; d >= 0; d--) begin
      if (d >= int'(idx_q) && ch_desc_en_i[int'(ch_q)*NUM_DESC + d] &&
          ch_desc_byt_i[(int'(ch_q)*NUM_DESC + d)*BYTES_W +: BYTES_W] != '0) begin
        sel_ok = 1'b1;
        sel_d  = DI_W'(d);
        src_d  = ch_desc_src_i[(int'(ch_q)*NUM_DESC + d)*ADDR_W +: ADDR_W];
        dst_d  = ch_desc_dst_i[(int'(ch_q)*NUM_DESC + d)*ADDR_W +: ADDR_W];
        byt_d  = ch_desc_byt_i[(int'(ch_q)*NUM_DESC + d)*BYTES_W +: BYTES_W];
      end
    end
  end
  // Next state and request valid; an abort is only honoured before valid has gone high
  always_comb begin
    state_d  = state_q;
    valid    = 1'b0;
    fin_done = 1'b0;
    unique case (state_q)
      IDLE:  state_d = gnt_ok ? ISSUE : IDLE;
      ISSUE: begin
        if (abort_q && !vld_q) state_d = IDLE;
        else if (!sel_ok) begin
          state_d  = IDLE;
          fin_done = 1'b1;
        end else begin
          valid   = 1'b1;
          state_d = eng.eng_req_ready_i ? WAIT : ISSUE;
        end
      end
      WAIT:  state_d = (eng.eng_err_i || (eng.eng_done_i && abort_q)) ? IDLE :
                       eng.eng_done_i ? ISSUE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  assign fin_end  = state_q != IDLE && state_d == IDLE;
  assign clr_mask = (fin_end ? ch_oh : '0) | (ch_abort_i & pend_q & ~act_oh);
  // State, channel bookkeeping and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
      vld_q   <= 1'b0;
      ch_q    <= '0;
      rr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= (pend_q | ch_go_i) & ~clr_mask;
      done_q  <= (done_q & ~irq_clr_i) | (fin_done ? ch_oh : '0);
      err_q   <= (err_q & ~irq_clr_i) | (state_q == WAIT && eng.eng_err_i ? ch_oh : '0);
      abort_q <= state_d == IDLE ? 1'b0 : abort_q | (state_q != IDLE && ch_abort_i[ch_q]);
      vld_q   <= valid && !eng.eng_req_ready_i;
      if (state_q == IDLE && gnt_ok) begin
        ch_q  <= gnt_ch;
        idx_q <= '0;
        rr_q  <= gnt_ch == CH_W'(NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
      end else if (valid && eng.eng_req_ready_i) idx_q <= sel_d + 1'b1;
    end
  end
  assign eng.eng_req_valid_o = valid;
  assign eng.eng_src_o       = valid ? src_d : '0;
  assign eng.eng_dst_o       = valid ? dst_d : '0;
  assign eng.eng_byt_o       = valid ? byt_d : '0;
  assign eng.eng_ch_o        = valid ? ch_q : '0;
  assign ch_busy_o           = pend_q;
  assign ch_done_o           = done_q;
  assign ch_err_o            = err_q;
  assign irq_done_o          = |(done_q & ~irq_mask_i);
  assign irq_error_o         = |(err_q & ~irq_mask_i);
endmodule

// File: tb/tb_axi_dma_ch_sched.sv
// tb_axi_dma_ch_sched: directed self-checking bench for the channel scheduler
module tb_axi_dma_ch_sched;
  logic clk = 0, rst = 1;
  logic [3:0] go = 0, abort = 0, mask = 0, clr = 0;
  logic [255:0] src_v = 0, dst_v = 0;
  logic [255:0] byt_v = 0;
  logic [7:0] en_v = 0;
  logic [3:0] busy, done, err;
  logic irq_d, irq_e;
  int n_chk = 0, n_fail = 0;
  axi_dma_ch_sched_if #(.ADDR_W(32), .BYTES_W(32), .CH_W(2)) eif();
  axi_dma_ch_sched #(.NUM_CH(4), .NUM_DESC(2), .ADDR_W(32), .BYTES_W(32)) dut (
    .clk(clk), .rst(rst), .ch_go_i(go), .ch_abort_i(abort),
    .ch_desc_src_i(src_v), .ch_desc_dst_i(dst_v), .ch_desc_byt_i(byt_v), .ch_desc_en_i(en_v),
    .irq_mask_i(mask), .irq_clr_i(clr), .eng(eif),
    .ch_busy_o(busy), .ch_done_o(done), .ch_err_o(err),
    .irq_done_o(irq_d), .irq_error_o(irq_e)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic setd(input int c, input int d, input logic e, input logic [31:0] b);
    src_v[(c*2+d)*32 +: 32] = 32'hA000_0000 + 32'(c*256 + d*16);
    dst_v[(c*2+d)*32 +: 32] = 32'hB000_0000 + 32'(c*256 + d*16);
    byt_v[(c*2+d)*32 +: 32] = b;
    en_v[c*2+d] = e;
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !eif.eng_req_valid_o; i++) tick();
    chk(tag, eif.eng_req_valid_o, 1);
  endtask
  task automatic xfer(input string tag, input int c, input int d, input logic [31:0] b);
    wait_valid(tag);
    chk({tag, "_ch"}, eif.eng_ch_o, c);
    chk({tag, "_src"}, eif.eng_src_o, 32'hA000_0000 + 32'(c*256 + d*16));
    chk({tag, "_dst"}, eif.eng_dst_o, 32'hB000_0000 + 32'(c*256 + d*16));
    chk({tag, "_byt"}, eif.eng_byt_o, b);
    eif.eng_req_ready_i = 1;
    tick();
    eif.eng_req_ready_i = 0;
    chk({tag, "_wait_novalid"}, eif.eng_req_valid_o, 0);
    eif.eng_done_i = 1;
    tick();
    eif.eng_done_i = 0;
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy != 0; i++) tick();
    chk(tag, busy, 0);
  endtask
  initial begin
    eif.eng_req_ready_i = 0;
    eif.eng_done_i = 0;
    eif.eng_err_i = 0;
    tick();
    tick();
    rst = 0;
    chk("rst_valid", eif.eng_req_valid_o, 0);
    chk("rst_src", eif.eng_src_o, 0);
    chk("rst_ch", eif.eng_ch_o, 0);
    chk("rst_status", {busy, done, err, irq_d, irq_e}, 0);
    setd(1, 0, 1, 64);
    setd(1, 1, 1, 128);
    go = 4'b0010;
    tick();
    go = 0;
    chk("t1_busy", busy, 4'b0010);
    chk("t1_novalid", eif.eng_req_valid_o, 0);
    tick();
    chk("t1_valid_lat", eif.eng_req_valid_o, 1);
    xfer("t1_d0", 1, 0, 64);
    xfer("t1_d1", 1, 1, 128);
    chk("t1_nodone_yet", done, 0);
    tick();
    chk("t1_done", done, 4'b0010);
    chk("t1_irq", irq_d, 1);
    chk("t1_idle", busy, 0);
    clr = 4'b0010;
    tick();
    clr = 0;
    chk("t1_clr", {done, irq_d}, 0);
    rst = 1;
    tick();
    rst = 0;
    setd(0, 0, 1, 16);
    setd(0, 1, 0, 0);
    setd(2, 0, 1, 32);
    setd(2, 1, 0, 0);
    setd(3, 0, 1, 48);
    setd(3, 1, 0, 0);
    go = 4'b1101;
    tick();
    go = 0;
    chk("t2_busy", busy, 4'b1101);
    xfer("t2_a", 0, 0, 16);
    xfer("t2_b", 2, 0, 32);
    go = 4'b0001;
    tick();
    go = 0;
    xfer("t2_c", 3, 0, 48);
    xfer("t2_d", 0, 0, 16);
    wait_idle("t2_idle");
    chk("t2_done", done, 4'b1101);
    clr = 4'b1111;
    tick();
    clr = 0;
    setd(2, 0, 1, 0);
    go = 4'b0100;
    tick();
    go = 0;
    chk("t3_n", {eif.eng_req_valid_o, done[2], busy[2]}, 3'b001);
    tick();
    chk("t3_n1", {eif.eng_req_valid_o, done[2]}, 2'b00);
    tick();
    chk("t3_n2", {eif.eng_req_valid_o, done[2], busy[2]}, 3'b010);
    clr = 4'b1111;
    tick();
    clr = 0;
    setd(0, 1, 1, 80);
    go = 4'b0001;
    tick();
    go = 0;
    wait_valid("t4_valid");
    chk("t4_byt", eif.eng_byt_o, 16);
    eif.eng_req_ready_i = 1;
    tick();
    eif.eng_req_ready_i = 0;
    eif.eng_err_i = 1;
    eif.eng_done_i = 1;
    tick();
    eif.eng_err_i = 0;
    eif.eng_done_i = 0;
    chk("t4_err", {err, done, busy}, 12'h100);
    chk("t4_irq", irq_e, 1);
    tick();
    tick();
    chk("t4_no_d1", eif.eng_req_valid_o, 0);
    mask = 4'b0001;
    #1;
    chk("t4_mask", irq_e, 0);
    mask = 0;
    clr = 4'b1111;
    tick();
    clr = 0;
    setd(3, 1, 1, 96);
    go = 4'b1000;
    tick();
    go = 0;
    wait_valid("t5_valid");
    chk("t5_ch", eif.eng_ch_o, 3);
    go = 4'b0010;
    tick();
    go = 0;
    eif.eng_req_ready_i = 1;
    tick();
    eif.eng_req_ready_i = 0;
    abort = 4'b1000;
    tick();
    abort = 0;
    eif.eng_done_i = 1;
    tick();
    eif.eng_done_i = 0;
    chk("t5_abort", {busy, done, err}, 12'h200);
    wait_valid("t5_next");
    chk("t5_next_ch", eif.eng_ch_o, 1);
    go = 4'b0100;
    tick();
    go = 0;
    chk("t5_pend2", busy, 4'b0110);
    abort = 4'b0100;
    tick();
    abort = 0;
    chk("t5_pend_abort", busy, 4'b0010);
    xfer("t5_d0", 1, 0, 64);
    xfer("t5_d1", 1, 1, 128);
    wait_idle("t5_idle");
    chk("t5_done", done, 4'b0010);
    go = 4'b0010;
    tick();
    go = 0;
    wait_valid("t6_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_hold", {eif.eng_req_valid_o, eif.eng_src_o, eif.eng_byt_o}, {1'b1, 32'hA000_0100, 32'd64});
    end
    eif.eng_req_ready_i = 1;
    tick();
    eif.eng_req_ready_i = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("t6_rst", {eif.eng_req_valid_o, eif.eng_byt_o, busy, done, err, irq_d, irq_e}, 0);
    eif.eng_done_i = 1;
    tick();
    eif.eng_done_i = 0;
    tick();
    chk("t6_ignored", {eif.eng_req_valid_o, busy, done, err}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
